// File: rtl/rsh_n_pkg.sv
// Shared definitions for the rsh_n constant-distance right shifter:
// data-width helper and the per-sample shift mode encoding.
package rsh_n_pkg;

    // Word width in bits for a given log2 width.
    function automatic int data_width(input int n);
        return 2 ** n;
    endfunction

    // Per-sample mode encoding carried on the arith input.
    localparam logic RSH_LOGICAL = 1'b0;
    localparam logic RSH_ARITH   = 1'b1;

endpackage : rsh_n_pkg

// File: rtl/rsh_n_comb.sv
// Combinational core of the rsh_n shifter: constant right shift by SHFT,
// zero or sign fill, and optional round-half-up.
// Optional feature macro: RSH_N_ROUND_EN (adds the last shifted-out bit
// to the result; otherwise the shift truncates).
module rsh_n_comb
    import rsh_n_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int SHFT = 2,
    localparam int W    = data_width(N)
) (
    input  logic [W-1:0] a,
    input  logic         arith,
    output logic [W-1:0] y
);

    // A shift distance outside 0..W has no meaning for a W-bit word.
    if (SHFT < 0 || SHFT > W) begin : g_bad_shft
        $fatal(1, "rsh_n_comb: SHFT=%0d outside legal range 0..%0d", SHFT, W);
    end

    logic         fill;
    logic [W-1:0] fill_mask;
    logic [W-1:0] shifted;

    // Sign fill only applies to negative operands in arithmetic mode.
    assign fill      = (arith == RSH_ARITH) && a[W-1];

    // Ones in the top SHFT positions; a shift by W clears every bit of the
    // all-ones word, so SHFT=W gives an all-ones mask without special casing.
    assign fill_mask = ~({W{1'b1}} >> SHFT);

    assign shifted   = (a >> SHFT) | (fill ? fill_mask : '0);

`ifdef RSH_N_ROUND_EN
    logic round_bit;

    // The most significant discarded bit is the half-LSB; with no shift
    // there is nothing discarded and no rounding.
    if (SHFT == 0) begin : g_no_round
        assign round_bit = 1'b0;
    end else begin : g_round
        assign round_bit = a[SHFT-1];
    end

    // Round half up in the selected mode. For SHFT>=1 the sum cannot
    // overflow the representable range, so no saturation is needed.
    assign y = shifted + {{(W-1){1'b0}}, round_bit};
`else
    // Truncation: toward 0 in logical mode, toward -inf in arithmetic mode.
    assign y = shifted;
`endif

endmodule : rsh_n_comb

// File: rtl/rsh_n_shift.sv
// Registered constant-distance right shifter for a 2**N-bit word; divides
// each valid sample by 2**SHFT with one clock of latency.
// Optional feature macro: RSH_N_ROUND_EN (round half up instead of truncate).
module rsh_n_shift
    import rsh_n_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int SHFT = 2,
    localparam int W    = data_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         arith,
    input  logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         out_valid
);

    logic [W-1:0] shifted;

    rsh_n_comb #(
        .N    (N),
        .SHFT (SHFT)
    ) u_comb (
        .a     (a),
        .arith (arith),
        .y     (shifted)
    );

    // Output and valid registers: capture a result on each valid cycle,
    // hold the last result otherwise; reset discards any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, so simulation matches the synthesized flops.
            out_valid <= in_valid;
            if (in_valid) begin
                b <= shifted;
            end
        end
    end

endmodule : rsh_n_shift

// File: tb/tb_rsh_n_shift.sv
// Directed self-checking bench for rsh_n_shift. Three instances share the
// stimulus: SHFT=2 (main), SHFT=0 (pass-through) and SHFT=8 (full width).
// Expected values are hand-computed; RSH_N_ROUND_EN selects the rounded set.
module tb_rsh_n_shift;

`ifdef RSH_N_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       arith;
    logic [7:0] a;
    logic [7:0] b2, b0, b8;
    logic       ov2, ov0, ov8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rsh_n_shift #(.N(3), .SHFT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .arith(arith), .a(a),
        .b(b2), .out_valid(ov2)
    );

    rsh_n_shift #(.N(3), .SHFT(0)) dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .arith(arith), .a(a),
        .b(b0), .out_valid(ov0)
    );

    rsh_n_shift #(.N(3), .SHFT(8)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .arith(arith), .a(a),
        .b(b8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is short; anything longer means a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    // Drive one input set on the falling edge, away from the active edge.
    task automatic drive(input logic v, input logic ar, input logic [7:0] val);
        @(negedge clk);
        in_valid = v;
        arith    = ar;
        a        = val;
    endtask

    // Advance through the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; arith = 1'b0; a = 8'h00;
        #1;
        total_cnt++;
        if (b2 !== 8'h00 || ov2 !== 1'b0)
            $display("FAIL reset_initial: b=%h ov=%b, required b=00 ov=0", b2, ov2);
        else pass_cnt++;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;

        // Stream a sample, then assert reset mid-cycle with in_valid still high.
        drive(1'b1, 1'b0, 8'hB6);
        tick();
        total_cnt++;
        if (ov2 !== 1'b1 || b2 !== (ROUND ? 8'h2E : 8'h2D))
            $display("FAIL reset_prestream: b=%h ov=%b, required b=%h ov=1",
                     b2, ov2, ROUND ? 8'h2E : 8'h2D);
        else pass_cnt++;
        drive(1'b1, 1'b1, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (b2 !== 8'h00 || ov2 !== 1'b0)
            $display("FAIL reset_async: b=%h ov=%b, required b=00 ov=0", b2, ov2);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b2 !== 8'h00 || ov2 !== 1'b0)
            $display("FAIL reset_held: b=%h ov=%b, required b=00 ov=0", b2, ov2);
        else pass_cnt++;

        // Release and confirm the first valid sample appears one edge later.
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; arith = 1'b0; a = 8'hFF;
        #1;
        total_cnt++;
        if (ov2 !== 1'b0)
            $display("FAIL reset_release_no_edge: ov=%b, required 0", ov2);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ov2 !== 1'b1 || b2 !== (ROUND ? 8'h40 : 8'h3F))
            $display("FAIL reset_first_sample: b=%h ov=%b, required b=%h ov=1",
                     b2, ov2, ROUND ? 8'h40 : 8'h3F);
        else pass_cnt++;
    endtask

    task automatic test_shift_modes();
        logic [7:0] va [4]   = '{8'hB6, 8'hB6, 8'hFF, 8'hFF};
        logic       vm [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] vt [4]   = '{8'h2D, 8'hED, 8'h3F, 8'hFF};
        logic [7:0] vr [4]   = '{8'h2E, 8'hEE, 8'h40, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vm[i], va[i]);
            tick();
            total_cnt++;
            if (ov2 !== 1'b1 || b2 !== (ROUND ? vr[i] : vt[i]))
                $display("FAIL shift_mode[%0d] a=%h arith=%b: b=%h ov=%b, required b=%h ov=1",
                         i, va[i], vm[i], b2, ov2, ROUND ? vr[i] : vt[i]);
            else pass_cnt++;
            total_cnt++;
            if (b0 !== va[i])
                $display("FAIL shft0_pass[%0d]: b=%h, required %h", i, b0, va[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_width();
        // SHFT=8 with a=80: logical gives 0 (+1 when rounding half up),
        // arithmetic gives all sign copies FF (wraps to 00 when rounding).
        drive(1'b1, 1'b0, 8'h80);
        tick();
        total_cnt++;
        if (ov8 !== 1'b1 || b8 !== (ROUND ? 8'h01 : 8'h00))
            $display("FAIL shft8_logical: b=%h ov=%b, required b=%h ov=1",
                     b8, ov8, ROUND ? 8'h01 : 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (b0 !== 8'h80)
            $display("FAIL shft0_pass_80_log: b=%h, required 80", b0);
        else pass_cnt++;
        drive(1'b1, 1'b1, 8'h80);
        tick();
        total_cnt++;
        if (b8 !== (ROUND ? 8'h00 : 8'hFF))
            $display("FAIL shft8_arith: b=%h, required %h", b8, ROUND ? 8'h00 : 8'hFF);
        else pass_cnt++;
        total_cnt++;
        if (b0 !== 8'h80)
            $display("FAIL shft0_pass_80_ar: b=%h, required 80", b0);
        else pass_cnt++;
        drive(1'b1, 1'b1, 8'h7F);
        tick();
        total_cnt++;
        if (b8 !== 8'h00 || b0 !== 8'h7F)
            $display("FAIL shft8_positive: b8=%h b0=%h, required b8=00 b0=7F", b8, b0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [6] = '{8'h12, 8'h7F, 8'h80, 8'h03, 8'hC5, 8'h5A};
        logic       vm [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] vt [6] = '{8'h04, 8'h1F, 8'hE0, 8'h00, 8'hF1, 8'h16};
        logic [7:0] vr [6] = '{8'h05, 8'h20, 8'hE0, 8'h01, 8'hF1, 8'h17};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vm[i], va[i]);
            tick();
            total_cnt++;
            if (ov2 !== 1'b1 || b2 !== (ROUND ? vr[i] : vt[i]))
                $display("FAIL back_to_back[%0d] a=%h: b=%h ov=%b, required b=%h ov=1",
                         i, va[i], b2, ov2, ROUND ? vr[i] : vt[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle_hold();
        logic [7:0] held;
        held = ROUND ? 8'h17 : 8'h16;   // last back-to-back result (a=5A)
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'hA5 ^ 8'(i));
            tick();
            total_cnt++;
            if (ov2 !== 1'b0 || b2 !== held)
                $display("FAIL idle_hold[%0d]: b=%h ov=%b, required b=%h ov=0",
                         i, b2, ov2, held);
            else pass_cnt++;
        end
        drive(1'b1, 1'b0, 8'h40);
        tick();
        total_cnt++;
        if (ov2 !== 1'b1 || b2 !== 8'h10)
            $display("FAIL idle_resume: b=%h ov=%b, required b=10 ov=1", b2, ov2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_shift_modes();
        test_full_width();
        test_back_to_back();
        test_idle_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_rsh_n_shift
